seq_divider: RTL and testbench

Multi-cycle unsigned restoring divider, the inverse companion to the ripple-carry adder datapath. It takes a WIDTH-bit dividend and divisor on a start pulse and iterates one trial subtraction per clock. After WIDTH iterations it presents quotient and remainder with a one-cycle done pulse. It sits beside the adder in the arithmetic block and shares its full-adder-style bit-cell philosophy, using a borrow chain instead of a carry chain.

---
 rtl/arith_pkg.sv | 16 +
 rtl/sub_stage.sv | 33 +++
 rtl/seq_divider.sv | 136 +++++++++++++
 tb/tb_seq_divider.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// ---------------------------------------------------------------------------
// arith_pkg
// Shared definitions for the arithmetic block: the sequential divider FSM
// state encoding and the default datapath width.
// ---------------------------------------------------------------------------
package arith_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : arith_pkg

// File: rtl/sub_stage.sv
// ---------------------------------------------------------------------------
// sub_stage
// Combinational N-bit ripple-borrow subtractor: diff = a - b.
// Built from full-subtractor bit cells chained through the borrow, the
// mirror image of the ripple-carry adder cell.
//
// Ports:
//   a    in  N  minuend
//   b    in  N  subtrahend
//   diff out N  a - b (modulo 2^N)
//   bout out 1  final borrow; 1 when a < b
// ---------------------------------------------------------------------------
module sub_stage #(
   parameter int N = 9
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] diff,
   output logic         bout
);

   logic [N:0] borrow;

   assign borrow[0] = 1'b0;

   for (genvar i = 0; i < N; i++) begin : g_cell
      assign diff[i]     = a[i] ^ b[i] ^ borrow[i];
      assign borrow[i+1] = (~a[i] & b[i]) | (borrow[i] & ~(a[i] ^ b[i]));
   end

   assign bout = borrow[N];

endmodule : sub_stage

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
// Multi-cycle unsigned restoring divider. One trial subtraction per clock;
// WIDTH iterations after an accepted start the results are presented with a
// one-cycle done pulse. A zero divisor skips iteration and reports
// quotient = all ones, remainder = dividend, div_by_zero = 1.
//
// Ports:
//   clk         in  1      rising-edge clock
//   rst         in  1      synchronous active-high reset
//   start       in  1      request, honoured only when busy = 0
//   dividend    in  WIDTH  numerator, sampled with accepted start
//   divisor     in  WIDTH  denominator, sampled with accepted start
//   busy        out 1      high while iterating
//   done        out 1      one-cycle pulse, results valid
//   quotient    out WIDTH  result, held until the next done
//   remainder   out WIDTH  result, held until the next done
//   div_by_zero out 1      divisor was zero, held with results
// ---------------------------------------------------------------------------
module seq_divider
   import arith_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   state_t           state, state_next;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] rem, quo, d;

   logic             accept;
   logic             last_iter;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   trial;
   logic             borrow;
   logic [WIDTH-1:0] rem_next, quo_next;
   logic             unused_trial_msb;

   // Start is honoured in IDLE and in DONE (back-to-back), never in RUN.
   assign accept    = start && (state != RUN);
   assign last_iter = (count == CW'(1));

   // Shifted partial remainder keeps the bit that falls out of rem, so the
   // trial subtraction is WIDTH+1 bits wide and can never overflow.
   assign rem_sh = {rem, quo[WIDTH-1]};

   sub_stage #(.N(WIDTH + 1)) u_sub (
      .a    (rem_sh),
      .b    ({1'b0, d}),
      .diff (trial),
      .bout (borrow)
   );

   // With no borrow the difference is < d, so its MSB is always zero.
   assign unused_trial_msb = trial[WIDTH];

   assign rem_next = borrow ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
   assign quo_next = {quo[WIDTH-2:0], ~borrow};

   // Outputs decode directly from the state register: no input-to-output path.
   assign busy = (state == RUN);
   assign done = (state == DONE);

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // NOTE: next state is defaulted before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE, DONE: begin
            if (accept) state_next = (divisor == '0) ? DONE : RUN;
            else        state_next = IDLE;
         end
         RUN: begin
            if (last_iter) state_next = DONE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count       <= '0;
         rem         <= '0;
         quo         <= '0;
         d           <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         if (accept) begin
            if (divisor == '0) begin
               // Shortcut straight to DONE with the defined zero-divisor result.
               quotient    <= '1;
               remainder   <= dividend;
               div_by_zero <= 1'b1;
            end else begin
               rem   <= '0;
               quo   <= dividend;
               d     <= divisor;
               count <= CW'(WIDTH);
            end
         end else if (state == RUN) begin
            rem   <= rem_next;
            quo   <= quo_next;
            count <= count - CW'(1);
            if (last_iter) begin
               // Results change only on entry to DONE, so they stay stable
               // through the following operation's RUN cycles.
               quotient    <= quo_next;
               remainder   <= rem_next;
               div_by_zero <= 1'b0;
            end
         end
      end
   end

endmodule : seq_divider

// File: tb/tb_seq_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_divider
// Directed self-checking bench for seq_divider (WIDTH = 8). Inputs change on
// the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seq_divider;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] dividend, divisor;
   logic         busy, done, div_by_zero;
   logic [W-1:0] quotient, remainder;

   int total = 0;
   int bad   = 0;

   seq_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Called at a falling edge; returns just after the accepting rising edge.
   task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Waits (bounded) for done, counting falling edges from the accept edge.
   // n0 edges have already elapsed (all of them busy) when called.
   // Returns at the falling edge inside the done cycle.
   task automatic finish_op(input string tag, input int n0, input int exp_lat,
                            input int exp_busy, input logic [W-1:0] eq,
                            input logic [W-1:0] er, input logic ez);
      int  n      = n0;
      int  busy_n = n0;
      int  both   = 0;
      bit  seen   = 1'b0;
      while (!seen && n < 20) begin
         @(negedge clk);
         n++;
         if (busy)         busy_n++;
         if (busy && done) both++;
         if (done)         seen = 1'b1;
      end
      check({tag, " seen"},    32'(seen),        32'd1);
      check({tag, " latency"}, n,                exp_lat);
      check({tag, " busy"},    busy_n,           exp_busy);
      check({tag, " overlap"}, both,             0);
      check({tag, " q"},       32'(quotient),    32'(eq));
      check({tag, " r"},       32'(remainder),   32'(er));
      check({tag, " dbz"},     32'(div_by_zero), 32'(ez));
   endtask

   logic [W-1:0] sweep_vals [12] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd7, 8'd16,
                                     8'd100, 8'd127, 8'd128, 8'd200, 8'd254, 8'd255};

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst busy", 32'(busy), 0);
      check("rst done", 32'(done), 0);
      check("rst q",    32'(quotient), 0);
      check("rst r",    32'(remainder), 0);
      check("rst dbz",  32'(div_by_zero), 0);
      rst = 1'b0;
      @(negedge clk);

      // 200/7 = 28 r 4
      launch(8'd200, 8'd7);
      finish_op("200/7", 0, 9, 8, 8'd28, 8'd4, 1'b0);
      @(negedge clk);
      check("done pulse width", 32'(done), 0);
      @(negedge clk);
      check("hold q", 32'(quotient), 28);
      check("hold r", 32'(remainder), 4);

      // Divisor larger than dividend, then divide by one
      launch(8'd5, 8'd9);
      finish_op("5/9", 0, 9, 8, 8'd0, 8'd5, 1'b0);
      @(negedge clk);
      launch(8'd255, 8'd1);
      finish_op("255/1", 0, 9, 8, 8'd255, 8'd0, 1'b0);
      @(negedge clk);

      // Divide by zero: done the cycle after start, busy never rises
      launch(8'd77, 8'd0);
      finish_op("77/0", 0, 1, 0, 8'd255, 8'd77, 1'b1);
      @(negedge clk);

      // Start pulsed during RUN is ignored
      launch(8'd100, 8'd10);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      dividend = 8'd50;
      divisor  = 8'd3;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      check("ignored busy", 32'(busy), 1);
      finish_op("ignored", 4, 9, 8, 8'd10, 8'd0, 1'b0);
      @(negedge clk);
      check("ignored no rerun", 32'(busy), 0);

      // Reset mid-operation discards the division
      launch(8'd200, 8'd7);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst busy", 32'(busy), 0);
      check("midrst done", 32'(done), 0);
      check("midrst q",    32'(quotient), 0);
      check("midrst r",    32'(remainder), 0);
      check("midrst dbz",  32'(div_by_zero), 0);
      launch(8'd9, 8'd2);
      finish_op("9/2", 0, 9, 8, 8'd4, 8'd1, 1'b0);

      // Back-to-back: second start issued in the done cycle of the first
      @(negedge clk);
      launch(8'd250, 8'd16);
      finish_op("250/16", 0, 9, 8, 8'd15, 8'd10, 1'b0);
      launch(8'd13, 8'd13);
      finish_op("13/13", 0, 9, 8, 8'd1, 8'd0, 1'b0);

      // Boundary sweep, every op launched back-to-back from a done cycle
      foreach (sweep_vals[i]) begin
         foreach (sweep_vals[j]) begin
            logic [W-1:0] a, b, eq, er;
            a = sweep_vals[i];
            b = sweep_vals[j];
            if (b == '0) begin
               eq = '1;
               er = a;
            end else begin
               eq = a / b;
               er = a % b;
            end
            launch(a, b);
            finish_op($sformatf("sweep %0d/%0d", a, b), 0,
                      (b == '0) ? 1 : 9, (b == '0) ? 0 : 8, eq, er, b == '0);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_seq_divider
